// File: rtl/bram_dual_requester_arbiter_if.sv
// Requester-side bundle for the dual-requester BRAM arbiter.
// Two write-only and two read-only requesters share one macro.
interface bram_dual_requester_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  wr0_valid;
  logic                  wr0_ready;
  logic [ADDR_WIDTH-1:0] wr0_addr;
  logic [DATA_WIDTH-1:0] wr0_data;
  logic [NUM_WMASKS-1:0] wr0_mask;
  logic                  wr1_valid;
  logic                  wr1_ready;
  logic [ADDR_WIDTH-1:0] wr1_addr;
  logic [DATA_WIDTH-1:0] wr1_data;
  logic [NUM_WMASKS-1:0] wr1_mask;
  logic                  rd0_valid;
  logic                  rd0_ready;
  logic [ADDR_WIDTH-1:0] rd0_addr;
  logic                  rd0_rvalid;
  logic [DATA_WIDTH-1:0] rd0_rdata;
  logic                  rd1_valid;
  logic                  rd1_ready;
  logic [ADDR_WIDTH-1:0] rd1_addr;
  logic                  rd1_rvalid;
  logic [DATA_WIDTH-1:0] rd1_rdata;

  modport master (
    output wr0_valid, wr0_addr, wr0_data, wr0_mask,
    output wr1_valid, wr1_addr, wr1_data, wr1_mask,
    output rd0_valid, rd0_addr,
    output rd1_valid, rd1_addr,
    input  wr0_ready, wr1_ready,
    input  rd0_ready, rd1_ready,
    input  rd0_rvalid, rd0_rdata,
    input  rd1_rvalid, rd1_rdata
  );

  modport slave (
    input  wr0_valid, wr0_addr, wr0_data, wr0_mask,
    input  wr1_valid, wr1_addr, wr1_data, wr1_mask,
    input  rd0_valid, rd0_addr,
    input  rd1_valid, rd1_addr,
    output wr0_ready, wr1_ready,
    output rd0_ready, rd1_ready,
    output rd0_rvalid, rd0_rdata,
    output rd1_rvalid, rd1_rdata
  );
endinterface

// File: rtl/bram_dual_requester_arbiter.sv
// Round-robin sharing of a 1RW1R SRAM macro between two requesters.
// Port 0 carries writes only, port 1 reads only.
module bram_dual_requester_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int HAZARD_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_dual_requester_arbiter_if.slave req,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int HW = $clog2(HAZARD_MAX + 1);

  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          rv_q, rv_d;
  logic          tag_q, tag_d;
  logic [HW-1:0] hcnt_q, hcnt_d;

  logic                  holdoff;
  logic                  w_any, w_sel, w_xfer, w_live;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NUM_WMASKS-1:0] w_mask;
  logic                  r_any, r_sel, r_xfer, hazard;
  logic [ADDR_WIDTH-1:0] r_addr;

  // On contention the requester not named by the pointer wins.
  always_comb begin
    holdoff = (hcnt_q == HW'(HAZARD_MAX));
    w_any   = req.wr0_valid | req.wr1_valid;
    w_sel   = (req.wr0_valid & req.wr1_valid) ?
              ~wr_ptr_q : req.wr1_valid;
    w_xfer  = w_any & ~holdoff;
    w_addr  = w_sel ? req.wr1_addr : req.wr0_addr;
    w_data  = w_sel ? req.wr1_data : req.wr0_data;
    w_mask  = w_sel ? req.wr1_mask : req.wr0_mask;
    w_live  = w_xfer & (|w_mask);
    r_any   = req.rd0_valid | req.rd1_valid;
    r_sel   = (req.rd0_valid & req.rd1_valid) ?
              ~rd_ptr_q : req.rd1_valid;
    r_addr  = r_sel ? req.rd1_addr : req.rd0_addr;
    hazard  = w_xfer & r_any & (w_addr == r_addr);
    r_xfer  = r_any & ~hazard;
  end

  assign req.wr0_ready = w_xfer & ~w_sel;
  assign req.wr1_ready = w_xfer &  w_sel;
  assign req.rd0_ready = r_xfer & ~r_sel;
  assign req.rd1_ready = r_xfer &  r_sel;

  // Idle write port parks on wr0 values to limit toggling.
  assign sram_csb0   = ~w_live;
  assign sram_web0   = ~w_live;
  assign sram_wmask0 = w_live ? w_mask : '0;
  assign sram_addr0  = w_xfer ? w_addr : req.wr0_addr;
  assign sram_din0   = w_xfer ? w_data : req.wr0_data;
  assign sram_csb1   = ~r_xfer;
  assign sram_addr1  = r_addr;

  assign req.rd0_rvalid = rv_q & ~tag_q;
  assign req.rd1_rvalid = rv_q &  tag_q;
  assign req.rd0_rdata  = sram_dout1;
  assign req.rd1_rdata  = sram_dout1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tag_d    = tag_q;
    rv_d     = r_xfer;
    hcnt_d   = '0;
    if (w_xfer) wr_ptr_d = w_sel;
    if (r_xfer) begin
      rd_ptr_d = r_sel;
      tag_d    = r_sel;
    end
    if (hazard && !holdoff) hcnt_d = hcnt_q + 1'b1;
    else if (hazard)        hcnt_d = hcnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rv_q     <= 1'b0;
      tag_q    <= 1'b0;
      hcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rv_q     <= rv_d;
      tag_q    <= tag_d;
      hcnt_q   <= hcnt_d;
    end
  end

endmodule

// File: tb/tb_bram_dual_requester_arbiter.sv
// Randomized and directed bench for the dual-requester BRAM arbiter.
// Includes a behavioural model of the SRAM macro.
module tb_bram_dual_requester_arbiter;
  localparam int HMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout1 = '0;

  bram_dual_requester_arbiter_if #(8, 32, 4) bus ();

  bram_dual_requester_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32),
    .NUM_WMASKS(4), .HAZARD_MAX(HMAX)
  ) dut (
    .clk(clk), .rst(rst), .req(bus),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_csb1(sram_csb1),
    .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;

  // Macro: capture on posedge, act on the following negedge.
  logic [31:0] mem [256];
  logic        l_we, l_re;
  logic [7:0]  l_a0, l_a1;
  logic [31:0] l_d0;
  logic [3:0]  l_m0;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    l_we = 0; l_re = 0;
  end
  always @(posedge clk) begin
    l_we <= !sram_csb0 && !sram_web0;
    l_a0 <= sram_addr0; l_d0 <= sram_din0; l_m0 <= sram_wmask0;
    l_re <= !sram_csb1;
    l_a1 <= sram_addr1;
  end
  always @(negedge clk) begin
    if (l_we)
      for (int b = 0; b < 4; b++)
        if (l_m0[b]) mem[l_a0][8*b +: 8] = l_d0[8*b +: 8];
    if (l_re) sram_dout1 = mem[l_a1];
  end

  // Requester state and reference model.
  bit          w_v [2];
  logic [7:0]  w_a [2];
  logic [31:0] w_d [2];
  logic [3:0]  w_m [2];
  bit          r_v [2];
  logic [7:0]  r_a [2];
  logic [31:0] ref_mem [256];
  int          m_wptr, m_rptr, m_hcnt;
  bit          e_v;
  int          e_k;
  logic [31:0] e_d;
  bit          obs_wr [2], obs_rd [2], obs_rv [2];
  bit          obs_csb0;
  logic [31:0] obs_rdata [2];
  int          n_vec = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(output int wg, output int rg);
    int rc;
    bit hold, haz, ew;
    logic [31:0] nw;
    bus.wr0_valid = w_v[0]; bus.wr0_addr = w_a[0];
    bus.wr0_data  = w_d[0]; bus.wr0_mask = w_m[0];
    bus.wr1_valid = w_v[1]; bus.wr1_addr = w_a[1];
    bus.wr1_data  = w_d[1]; bus.wr1_mask = w_m[1];
    bus.rd0_valid = r_v[0]; bus.rd0_addr = r_a[0];
    bus.rd1_valid = r_v[1]; bus.rd1_addr = r_a[1];
    @(negedge clk); #3;
    hold = m_hcnt >= HMAX;
    wg = -1;
    if (!hold) begin
      if (w_v[0] && w_v[1]) wg = 1 - m_wptr;
      else if (w_v[0]) wg = 0;
      else if (w_v[1]) wg = 1;
    end
    rc = -1;
    if (r_v[0] && r_v[1]) rc = 1 - m_rptr;
    else if (r_v[0]) rc = 0;
    else if (r_v[1]) rc = 1;
    haz = wg >= 0 && rc >= 0 && w_a[wg] == r_a[rc];
    rg = haz ? -1 : rc;
    ew = 0;
    if (wg >= 0) ew = w_m[wg] != 0;
    chk("wr0_ready", bus.wr0_ready, wg == 0);
    chk("wr1_ready", bus.wr1_ready, wg == 1);
    chk("rd0_ready", bus.rd0_ready, rg == 0);
    chk("rd1_ready", bus.rd1_ready, rg == 1);
    chk("csb0", sram_csb0, !ew);
    chk("web0", sram_web0, !ew);
    if (ew) begin
      chk("wmask0", sram_wmask0, w_m[wg]);
      chk("addr0", sram_addr0, w_a[wg]);
      chk("din0", sram_din0, w_d[wg]);
    end else chk("wmask0_idle", sram_wmask0, 0);
    chk("csb1", sram_csb1, rg < 0);
    if (rg >= 0) chk("addr1", sram_addr1, r_a[rg]);
    chk("rd0_rvalid", bus.rd0_rvalid, e_v && e_k == 0);
    chk("rd1_rvalid", bus.rd1_rvalid, e_v && e_k == 1);
    if (e_v && e_k == 0) chk("rd0_rdata", bus.rd0_rdata, e_d);
    if (e_v && e_k == 1) chk("rd1_rdata", bus.rd1_rdata, e_d);
    obs_wr[0] = bus.wr0_ready;  obs_wr[1] = bus.wr1_ready;
    obs_rd[0] = bus.rd0_ready;  obs_rd[1] = bus.rd1_ready;
    obs_rv[0] = bus.rd0_rvalid; obs_rv[1] = bus.rd1_rvalid;
    obs_rdata[0] = bus.rd0_rdata; obs_rdata[1] = bus.rd1_rdata;
    obs_csb0 = sram_csb0;
    e_v = rg >= 0 && !rst;
    if (rg >= 0) begin
      e_k = rg;
      e_d = ref_mem[r_a[rg]];
    end
    if (ew) begin
      nw = ref_mem[w_a[wg]];
      for (int b = 0; b < 4; b++)
        if (w_m[wg][b]) nw[8*b +: 8] = w_d[wg][8*b +: 8];
      ref_mem[w_a[wg]] = nw;
    end
    if (rst) begin
      m_wptr = 0; m_rptr = 0; m_hcnt = 0;
    end else begin
      if (wg >= 0) m_wptr = wg;
      if (rg >= 0) m_rptr = rg;
      m_hcnt = (rg < 0 && haz) ? ((m_hcnt + 1 > HMAX) ? HMAX : m_hcnt + 1) : 0;
    end
    @(posedge clk); #1;
    if (wg >= 0) w_v[wg] = 0;
    if (rg >= 0) r_v[rg] = 0;
  endtask

  task automatic idle(int n);
    int wg, rg;
    for (int i = 0; i < n; i++) step(wg, rg);
  endtask

  task automatic wr(int k, logic [7:0] a, logic [31:0] d, logic [3:0] m);
    int wg, rg;
    w_v[k] = 1; w_a[k] = a; w_d[k] = d; w_m[k] = m;
    for (int i = 0; i < 8 && w_v[k]; i++) step(wg, rg);
    if (w_v[k]) begin
      chk("wr_timeout", 0, 1);
      w_v[k] = 0;
    end
  endtask

  task automatic rd_chk(int k, logic [7:0] a, logic [31:0] exp);
    int wg, rg;
    r_v[k] = 1; r_a[k] = a;
    for (int i = 0; i < 8 && r_v[k]; i++) step(wg, rg);
    if (r_v[k]) begin
      chk("rd_timeout", 0, 1);
      r_v[k] = 0;
    end
    step(wg, rg);
    chk("rd_rvalid", obs_rv[k], 1);
    chk("rd_other_rvalid", obs_rv[1-k], 0);
    chk("rd_data", obs_rdata[k], exp);
  endtask

  initial begin
    int wg, rg, idx0, idx1, n0, n1, stalls;
    bit done;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int k = 0; k < 2; k++) begin
      w_v[k] = 0; w_a[k] = 0; w_d[k] = 0; w_m[k] = 0;
      r_v[k] = 0; r_a[k] = 0;
    end
    m_wptr = 0; m_rptr = 0; m_hcnt = 0; e_v = 0; e_k = 0; e_d = 0;
    rst = 1;
    bus.wr0_valid = 0; bus.wr1_valid = 0;
    bus.rd0_valid = 0; bus.rd1_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    step(wg, rg);
    rst = 0;
    idle(10);

    wr(0, 8'h10, 32'hDEADBEEF, 4'hF);
    idle(1);
    rd_chk(1, 8'h10, 32'hDEADBEEF);

    w_v[0] = 1; w_v[1] = 1;
    idx0 = 0; idx1 = 0; n0 = 0; n1 = 0;
    w_a[0] = 8'h50; w_d[0] = $urandom; w_m[0] = 4'hF;
    w_a[1] = 8'h58; w_d[1] = $urandom; w_m[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step(wg, rg);
      chk("alt_wr1", obs_wr[1], (i % 2) == 0);
      chk("alt_wr0", obs_wr[0], (i % 2) == 1);
      if (obs_wr[0]) begin
        n0++; idx0++;
        if (idx0 < 4) begin
          w_v[0] = 1; w_a[0] = 8'h50 + 8'(idx0); w_d[0] = $urandom;
        end
      end
      if (obs_wr[1]) begin
        n1++; idx1++;
        if (idx1 < 4) begin
          w_v[1] = 1; w_a[1] = 8'h58 + 8'(idx1); w_d[1] = $urandom;
        end
      end
    end
    chk("wr0_count", n0, 4);
    chk("wr1_count", n1, 4);
    w_v[0] = 0; w_v[1] = 0;
    for (int i = 0; i < 8; i++)
      rd_chk(0, 8'h50 + 8'(i), ref_mem[8'h50 + 8'(i)]);

    w_v[0] = 1; w_a[0] = 8'h20; w_d[0] = 32'h11111111; w_m[0] = 4'hF;
    r_v[0] = 1; r_a[0] = 8'h20;
    step(wg, rg);
    chk("haz_rd0_blocked", obs_rd[0], 0);
    chk("haz_wr0_granted", obs_wr[0], 1);
    step(wg, rg);
    chk("haz_rd0_retry", obs_rd[0], 1);
    step(wg, rg);
    chk("haz_rvalid", obs_rv[0], 1);
    chk("haz_rdata", obs_rdata[0], 32'h11111111);

    idle(1);
    w_v[1] = 1; w_a[1] = 8'h30; w_d[1] = $urandom; w_m[1] = 4'hF;
    r_v[1] = 1; r_a[1] = 8'h30;
    stalls = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      step(wg, rg);
      if (obs_rd[1]) begin
        done = 1;
        chk("starve_wr1_held", obs_wr[1], 0);
      end else begin
        stalls++;
        w_v[1] = 1; w_d[1] = $urandom;
      end
    end
    chk("starve_stalls", stalls, 4);
    w_v[1] = 0;
    step(wg, rg);
    chk("starve_rvalid", obs_rv[1], 1);

    wr(0, 8'h40, 32'hAABBCCDD, 4'hF);
    wr(0, 8'h40, 32'h00550000, 4'b0100);
    rd_chk(0, 8'h40, 32'hAA55CCDD);
    w_v[0] = 1; w_a[0] = 8'h40; w_d[0] = 32'h12345678; w_m[0] = 4'h0;
    step(wg, rg);
    chk("zmask_ready", obs_wr[0], 1);
    chk("zmask_csb0", obs_csb0, 1);
    rd_chk(0, 8'h40, 32'hAA55CCDD);

    r_v[0] = 1; r_a[0] = 8'h40;
    rst = 1;
    step(wg, rg);
    chk("rst_rd0_accept", obs_rd[0], 1);
    rst = 0;
    step(wg, rg);
    chk("rst_no_rvalid", obs_rv[0], 0);

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!w_v[k] && $urandom_range(0, 1) == 1) begin
          w_v[k] = 1; w_a[k] = 8'($urandom_range(0, 7));
          w_d[k] = $urandom; w_m[k] = 4'($urandom_range(0, 15));
        end
        if (!r_v[k] && $urandom_range(0, 1) == 1) begin
          r_v[k] = 1; r_a[k] = 8'($urandom_range(0, 7));
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      step(wg, rg);
    end
    rst = 0;
    w_v[0] = 0; w_v[1] = 0;
    r_v[0] = 0; r_v[1] = 0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
